ransac_inlier_scorer: RTL
=========================

# ransac_inlier_scorer

Scores candidate planes for RANSAC by consuming the per-point absolute distance stream from the point-to-plane distance stage. Counts inliers within a programmable threshold per candidate and keeps the best plane seen so far. Signals completion after a fixed number of candidate planes. Sits directly downstream of the distance stage and feeds the final plane-refit/output logic.

## Interface
- `max_points`, default 4096: maximum points per candidate; sets the count width `count_bits = $clog2(max_points+1)`.
- `max_iterations`, default 64: number of candidate planes scored per run.
- `early_exit_count`, default 3072: inlier count that ends a run early; used only with the macro.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start`  in  1: pulse; clears best/iteration state and begins a run.
- `threshold`  in  `fixed_t`: inlier bound; sampled every valid cycle.
- `valid_i`  in  1: `distance`/`plane`/`last_i` are meaningful this cycle.
- `distance`  in  `fixed_t`: non-negative distance of one point to `plane`.
- `plane`  in  `plane_t`: candidate plane the distance belongs to.
- `last_i`  in  1: final point of the current candidate.
- `score_valid`  out  1: one-cycle pulse; a candidate was committed.
- `score`  out  `count_bits`: inlier count of the just-committed candidate.
- `best_plane`  out  `plane_t`: plane with the highest count this run.
- `best_count`  out  `count_bits`: count of `best_plane`.
- `iteration`  out  `$clog2(max_iterations+1)`: candidates committed this run.
- `busy`  out  1: high in SCORING.
- `done`  out  1: high in DONE.

## Operation
- States: IDLE (reset), SCORING, DONE.
- IDLE → SCORING on `start`. DONE → SCORING on `start`. `start` in SCORING restarts the run. Entering SCORING clears `best_count`, `best_plane`, `iteration` and the running count.
- In SCORING, each `valid_i` cycle counts an inlier when `distance <= threshold` (inclusive, signed fixed compare).
- The running count saturates at `max_points`.
- `valid_i` && `last_i`: the current point is included. Then `score` = final count and `score_valid` pulses.
  - If `score > best_count` (strict), `best_plane` ← the `plane` present on the `last_i` cycle and `best_count` ← `score`. Ties keep the earlier plane.
  - `iteration` increments and the running count resets to 0.
- When `iteration` reaches `max_iterations` on a commit, the block moves to DONE on that edge.
- `valid_i` in IDLE or DONE is ignored. `best_*` hold in DONE until the next `start`.
- `start` and `valid_i` in the same cycle: `start` wins and the sample is dropped.

## Timing
- Throughput is one sample per cycle. Back-to-back candidates (a `last_i` followed immediately by the next plane's first point) are supported with no bubble.
- `score`, `score_valid`, `best_*`, `iteration` and `done` update on the edge that samples `last_i`, so they are visible one cycle after.
- Reset values: all outputs 0. `best_plane` is all-zero. State is IDLE.
- Reset mid-run aborts immediately. No partial commit.

## Configuration
- `RANSAC_SCORER_EARLY_EXIT_EN` defined: after a commit with `score >= early_exit_count`, go to DONE on that edge regardless of `iteration`.
- Not defined: runs always complete `max_iterations` candidates, and `early_exit_count` is unused.

## Structure
- Add `scorer_state_t` to the shared `ransac_fixed` package. `fixed_t`/`plane_t` already come from that package.
- Count-width helper functions also go in the package.
- One sub-module: `inlier_counter`, which holds the threshold compare, the saturating count and the last-point flush. The FSM and best-plane tracking live in the top.

## Test plan
- Reset, then `start`, then 4 points with `threshold` = 1.0 and distances 0.5, 1.0, 1.5, 0.0 (`last_i` on the 4th) → `score` = 3, `score_valid` one pulse, `best_count` = 3, `iteration` = 1.
- Three back-to-back candidates with counts 2, 5, 5 → `best_count` = 5 and `best_plane` = the second plane, which proves the tie keeps the earlier plane.
- `max_iterations` = 2, two candidates → `done` high the cycle after the second commit. A later `valid_i` leaves state unchanged. `start` clears `best_count` to 0.
- Assert `reset` mid-candidate after 3 inliers → all outputs 0 at once, state IDLE. No `score_valid`.
- With `RANSAC_SCORER_EARLY_EXIT_EN` and `early_exit_count` = 3, first candidate scores 3 → `done` after 1 iteration. Without the macro, scoring continues.
- `max_points` = 4 with 6 inlier points → `score` saturates at 4.

Source files
------------

// File: rtl/ransac_fixed_pkg.sv
// Shared fixed-point types for the RANSAC plane pipeline, plus the scorer FSM
// state type and the counter-width helpers.
package ransac_fixed;

  // Q8.8 signed fixed point
  typedef logic signed [15:0] fixed_t;

  typedef struct packed {
    fixed_t a;
    fixed_t b;
    fixed_t c;
    fixed_t d;
  } plane_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCORING,
    ST_DONE
  } scorer_state_t;

  // bits needed to hold values 0..n inclusive
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ransac_inlier_scorer_inlier_counter.sv
// Per-candidate inlier counter: threshold compare, saturating count, and a
// flush back to zero on the last point of each candidate.
module inlier_counter
  import ransac_fixed::*;
#(
  parameter int unsigned max_points = 4096,
  parameter int unsigned count_bits = count_width(max_points)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  sample,
  input  logic                  last_i,
  input  fixed_t                distance,
  input  fixed_t                threshold,
  output logic [count_bits-1:0] total
);

  logic [count_bits-1:0] count;
  logic                  hit;

  assign hit = (distance <= threshold);

  // total includes the point presented this cycle, so a commit can use it directly
  always_comb begin
    total = count;
    if (hit && (count != count_bits'(max_points)))
      total = count + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (sample)
      count <= last_i ? '0 : total;
  end

endmodule

// File: rtl/ransac_inlier_scorer.sv
// RANSAC inlier scorer: counts inliers per candidate plane and tracks the best.
// Optional early exit enabled by defining RANSAC_SCORER_EARLY_EXIT_EN.
module ransac_inlier_scorer
  import ransac_fixed::*;
#(
  parameter int unsigned max_points       = 4096,
  parameter int unsigned max_iterations   = 64,
  parameter int unsigned early_exit_count = 3072,
  localparam int unsigned count_bits      = count_width(max_points),
  localparam int unsigned iter_bits       = count_width(max_iterations)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  fixed_t                threshold,
  input  logic                  valid_i,
  input  fixed_t                distance,
  input  plane_t                plane,
  input  logic                  last_i,
  output logic                  score_valid,
  output logic [count_bits-1:0] score,
  output plane_t                best_plane,
  output logic [count_bits-1:0] best_count,
  output logic [iter_bits-1:0]  iteration,
  output logic                  busy,
  output logic                  done
);

`ifdef RANSAC_SCORER_EARLY_EXIT_EN
  localparam logic early_exit_on = 1'b1;
`else
  localparam logic early_exit_on = 1'b0;
`endif

  scorer_state_t         state, next_state;
  logic                  sample, commit, last_iter, early_hit;
  logic [count_bits-1:0] total;
  logic [iter_bits-1:0]  iter_next;

  // start takes priority: a sample arriving with start is dropped
  assign sample    = (state == ST_SCORING) && valid_i && !start;
  assign commit    = sample && last_i;
  assign iter_next = iteration + 1'b1;
  assign last_iter = (iter_next == iter_bits'(max_iterations));
  assign early_hit = early_exit_on && (32'(total) >= early_exit_count);

  inlier_counter #(
    .max_points (max_points),
    .count_bits (count_bits)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (start),
    .sample    (sample),
    .last_i    (last_i),
    .distance  (distance),
    .threshold (threshold),
    .total     (total)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_SCORING;
      ST_SCORING: if (start) next_state = ST_SCORING;
                  else if (commit && (last_iter || early_hit)) next_state = ST_DONE;
      ST_DONE:    if (start) next_state = ST_SCORING;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      score_valid <= 1'b0;
      score       <= '0;
      best_plane  <= '0;
      best_count  <= '0;
      iteration   <= '0;
    end else begin
      score_valid <= 1'b0;
      if (start) begin
        best_plane <= '0;
        best_count <= '0;
        iteration  <= '0;
      end else if (commit) begin
        score       <= total;
        score_valid <= 1'b1;
        iteration   <= iter_next;
        if (total > best_count) begin
          best_count <= total;
          best_plane <= plane;
        end
      end
    end
  end

  assign busy = (state == ST_SCORING);
  assign done = (state == ST_DONE);

endmodule
